// File: rtl/apb_cmd_master.sv
// APB requester: turns single local commands into APB SETUP/ACCESS transfers
// and returns a one-cycle completion pulse, aborting transfers that stall too long.
module apb_cmd_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [9:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        PSEL,
    output logic [9:0]  PADDR,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

    state_t     state;
    logic [9:0] wait_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            wait_cnt    <= 10'd0;
            cmd_ready   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= 10'd0;
            PWDATA      <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        PSEL      <= 1'b1;
                        PADDR     <= cmd_addr;
                        PWRITE    <= cmd_write;
                        PWDATA    <= cmd_wdata;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    PENABLE  <= 1'b1;
                    wait_cnt <= 10'd0;
                end
                ACCESS: begin
                    // A responder that answers on the final allowed cycle still wins.
                    if (PREADY) begin
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= PWRITE ? 32'd0 : PRDATA;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomised scoreboard bench for apb_cmd_master: a driver issues commands,
// a responder plays the APB slave, and a monitor checks every completion.
module tb_apb_cmd_master;

    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        PSEL;
    logic [9:0]  PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    apb_cmd_master #(.TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
    } apb_t;

    typedef struct {
        logic        to;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    apb_t apb_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   in_rst   = 1'b1;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int eff_waits(input int waits);
        return (waits > TO) ? TO : waits;
    endfunction

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Behavioural APB responder: PREADY rises after the chosen number of wait states.
    apb_t cur;
    int   acc = 0;
    bit   active = 1'b0;
    always @(negedge PCLK) begin
        if (in_rst) begin
            active = 1'b0;
            PREADY = 1'b0;
            PRDATA = 32'd0;
        end else if (PSEL && !PENABLE) begin
            if (apb_q.size() == 0) begin
                chk("apb_unexpected_setup", 32'(apb_q.size()), 32'd1);
            end else begin
                cur = apb_q.pop_front();
                chk("setup_paddr", 32'(PADDR), 32'(cur.addr));
                chk("setup_pwrite", 32'(PWRITE), 32'(cur.wr));
                chk("setup_pwdata", PWDATA, cur.wdata);
            end
            acc    = 0;
            active = 1'b1;
            PREADY = 1'($urandom_range(0, 1));
            PRDATA = $urandom;
        end else if (PSEL && PENABLE) begin
            chk("access_paddr", 32'(PADDR), 32'(cur.addr));
            chk("access_pwdata", PWDATA, cur.wdata);
            PREADY = (acc >= cur.waits);
            PRDATA = PREADY ? cur.prdata : $urandom;
            acc++;
        end else begin
            if (active) begin
                chk("access_len", 32'(acc), 32'(eff_waits(cur.waits) + 1));
                chk("penable_with_psel_low", 32'(PENABLE), 32'd0);
                active = 1'b0;
            end
            PREADY = 1'($urandom_range(0, 1));
            PRDATA = $urandom;
        end
    end

    // Response monitor: pops the scoreboard on every completion pulse.
    logic [31:0] last_rdata = 32'd0;
    logic        last_to    = 1'b0;
    always @(negedge PCLK) begin
        rsp_t e;
        if (in_rst) begin
            chk("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
            last_rdata = 32'd0;
            last_to    = 1'b0;
        end else if (rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_q.size()), 32'd1);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                chk("cmd_ready_at_rsp", 32'(cmd_ready), 32'd1);
                last_rdata = e.rdata;
                last_to    = e.to;
            end
        end else begin
            chk("rsp_rdata_hold", rsp_rdata, last_rdata);
            chk("rsp_timeout_hold", 32'(rsp_timeout), 32'(last_to));
        end
    end

    task automatic issue(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] prdata, input int gap);
        apb_t a;
        rsp_t r;
        int   guard;
        for (int i = 0; i < gap; i++) begin
            cmd_valid = 1'b0;
            @(negedge PCLK);
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        guard = 0;
        while (cmd_ready !== 1'b1) begin
            @(negedge PCLK);
            guard++;
            if (guard > 100) begin
                chk("cmd_accept_bound", 32'(cmd_ready), 32'd1);
                finish_test();
            end
        end
        a.wr = wr; a.addr = addr; a.wdata = wdata; a.waits = waits; a.prdata = prdata;
        r.to    = (waits > TO);
        r.rdata = (r.to || wr) ? 32'd0 : prdata;
        r.cyc   = cyc + 3 + eff_waits(waits);
        apb_q.push_back(a);
        rsp_q.push_back(r);
        @(negedge PCLK);
    endtask

    task automatic drain();
        int guard = 0;
        cmd_valid = 1'b0;
        while (rsp_q.size() != 0 || apb_q.size() != 0 || PSEL === 1'b1) begin
            @(negedge PCLK);
            guard++;
            if (guard > 200) begin
                chk("drain_bound", 32'(rsp_q.size()), 32'd0);
                finish_test();
            end
        end
        @(negedge PCLK);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_psel"}, 32'(PSEL), 32'd0);
        chk({tag, "_penable"}, 32'(PENABLE), 32'd0);
        chk({tag, "_pwrite"}, 32'(PWRITE), 32'd0);
        chk({tag, "_paddr"}, 32'(PADDR), 32'd0);
        chk({tag, "_pwdata"}, PWDATA, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 10'd0;
        cmd_wdata = 32'd0;
        repeat (3) @(negedge PCLK);
        check_reset_values("por");
        PRESETn = 1'b1;
        in_rst  = 1'b0;
        @(negedge PCLK);

        // Directed cases: zero-wait write, 3-wait read, stuck timeout, last-cycle ready.
        issue(1'b1, 10'h002, 32'h41, 0, 32'hDEAD_BEEF, 0);
        drain();
        issue(1'b0, 10'h001, 32'h0, 3, 32'h0000_0003, 0);
        drain();
        issue(1'b0, 10'h155, 32'h0, 100, 32'h1234_5678, 0);
        drain();
        issue(1'b0, 10'h0AA, 32'h0, TO, 32'h0000_00A5, 0);
        drain();
        issue(1'b1, 10'h010, 32'h1111_1111, 0, 32'h0, 0);
        issue(1'b1, 10'h011, 32'h2222_2222, 0, 32'h0, 0);
        issue(1'b1, 10'h012, 32'h3333_3333, 0, 32'h0, 0);
        drain();

        // Reset during a wait state: bus drops at once and the transfer vanishes.
        issue(1'b0, 10'h3FF, 32'hCAFE_F00D, 100, 32'h0, 0);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("pre_reset_penable", 32'(PENABLE), 32'd1);
        in_rst  = 1'b1;
        PRESETn = 1'b0;
        #1;
        chk("async_psel", 32'(PSEL), 32'd0);
        chk("async_penable", 32'(PENABLE), 32'd0);
        rsp_q.delete();
        apb_q.delete();
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check_reset_values("mid_rst");
        in_rst = 1'b0;
        @(negedge PCLK);

        for (int n = 0; n < 60; n++) begin
            int w;
            w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO + 1, TO + 4))
                                            : int'($urandom_range(0, TO));
            issue(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), $urandom,
                  w, $urandom, int'($urandom_range(0, 2)));
        end
        drain();
        finish_test();
    end

endmodule
